// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array core, tile scheduler and AXIS loaders.
package sa_pkg;

  typedef logic [7:0] dim_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_CMP = 2'd2,
    ST_WAIT_WR  = 2'd3
  } tile_state_t;

  localparam int SA_P  = 8;
  localparam int SA_Q  = 8;
  localparam int SA_KT = (SA_P < SA_Q) ? SA_P : SA_Q;

endpackage

// File: rtl/sa_tile_len.sv
// Length of one tile along a single dimension and whether it is the last tile there.
module sa_tile_len
  import sa_pkg::*;
#(
  parameter int TILE = SA_P
) (
  input  dim_t dim,
  input  dim_t off,
  output dim_t len,
  output logic last
);

  logic [8:0] rem;

  // 9-bit arithmetic so that off+TILE cannot wrap when dim is 255
  assign rem  = {1'b0, dim} - {1'b0, off};
  assign len  = (rem > 9'(TILE)) ? dim_t'(TILE) : rem[7:0];
  assign last = ({1'b0, off} + 9'(TILE)) >= {1'b0, dim};

endmodule

// File: rtl/sa_tile_scheduler.sv
// Walks an MxK by KxN multiply as m-tile, n-tile, k-tile (k innermost) and issues
// one registered tile command per k-step to the core and its loaders.
module sa_tile_scheduler
  import sa_pkg::*;
#(
  parameter int P  = SA_P,
  parameter int Q  = SA_Q,
  parameter int KT = (P < Q) ? P : Q
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  dim_t        cfg_m,
  input  dim_t        cfg_n,
  input  dim_t        cfg_k,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output dim_t        cmd_row_len,
  output dim_t        cmd_col_len,
  output dim_t        cmd_k_len,
  output logic        cmd_finish,
  output dim_t        cmd_m_off,
  output dim_t        cmd_n_off,
  output dim_t        cmd_k_off,
  input  logic        cmp_done,
  input  logic        wr_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] cmd_cnt
);

  tile_state_t state, state_nxt;
  dim_t        dim_m, dim_n, dim_k, dim_m_nxt, dim_n_nxt, dim_k_nxt;
  dim_t        m_off_nxt, n_off_nxt, k_off_nxt;
  dim_t        row_len_nxt, col_len_nxt, k_len_nxt;
  logic        m_last, n_last, m_last_nxt, n_last_nxt, finish_nxt;
  logic [15:0] cmd_cnt_nxt;
  logic        done_nxt, err_nxt, load_cmd, start_ok;

  assign start_ok = start && (cfg_m != '0) && (cfg_n != '0) && (cfg_k != '0);

  // Lengths are evaluated on the offsets the next command will carry
  sa_tile_len #(.TILE(P))  u_len_m (.dim(dim_m_nxt), .off(m_off_nxt), .len(row_len_nxt), .last(m_last_nxt));
  sa_tile_len #(.TILE(Q))  u_len_n (.dim(dim_n_nxt), .off(n_off_nxt), .len(col_len_nxt), .last(n_last_nxt));
  sa_tile_len #(.TILE(KT)) u_len_k (.dim(dim_k_nxt), .off(k_off_nxt), .len(k_len_nxt),   .last(finish_nxt));

  always_comb begin
    state_nxt   = state;
    dim_m_nxt   = dim_m;
    dim_n_nxt   = dim_n;
    dim_k_nxt   = dim_k;
    m_off_nxt   = cmd_m_off;
    n_off_nxt   = cmd_n_off;
    k_off_nxt   = cmd_k_off;
    cmd_cnt_nxt = cmd_cnt;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cmd_cnt_nxt = '0;
          if (start_ok) begin
            dim_m_nxt = cfg_m;
            dim_n_nxt = cfg_n;
            dim_k_nxt = cfg_k;
            m_off_nxt = '0;
            n_off_nxt = '0;
            k_off_nxt = '0;
            state_nxt = ST_ISSUE;
          end else begin
            err_nxt  = 1'b1;
            done_nxt = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_cnt_nxt = cmd_cnt + 16'd1;
          state_nxt   = ST_WAIT_CMP;
        end
      end
      ST_WAIT_CMP: begin
        if (cmp_done) begin
          if (cmd_finish) begin
            state_nxt = ST_WAIT_WR;
          end else begin
            k_off_nxt = cmd_k_off + dim_t'(KT);
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_WAIT_WR: begin
        if (wr_done) begin
          k_off_nxt = '0;
          if (n_last) begin
            n_off_nxt = '0;
            m_off_nxt = cmd_m_off + dim_t'(P);
          end else begin
            n_off_nxt = cmd_n_off + dim_t'(Q);
          end
          if (m_last && n_last) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over any handshake or completion event in the same cycle
    if (abort && state != ST_IDLE) begin
      state_nxt   = ST_IDLE;
      cmd_cnt_nxt = cmd_cnt;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
    end
  end

  assign load_cmd = (state_nxt == ST_ISSUE) && (state != ST_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dim_m       <= '0;
      dim_n       <= '0;
      dim_k       <= '0;
      cmd_row_len <= '0;
      cmd_col_len <= '0;
      cmd_k_len   <= '0;
      cmd_finish  <= 1'b0;
      cmd_m_off   <= '0;
      cmd_n_off   <= '0;
      cmd_k_off   <= '0;
      m_last      <= 1'b0;
      n_last      <= 1'b0;
      cmd_cnt     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state   <= state_nxt;
      dim_m   <= dim_m_nxt;
      dim_n   <= dim_n_nxt;
      dim_k   <= dim_k_nxt;
      cmd_cnt <= cmd_cnt_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      if (load_cmd) begin
        cmd_row_len <= row_len_nxt;
        cmd_col_len <= col_len_nxt;
        cmd_k_len   <= k_len_nxt;
        cmd_finish  <= finish_nxt;
        cmd_m_off   <= m_off_nxt;
        cmd_n_off   <= n_off_nxt;
        cmd_k_off   <= k_off_nxt;
        m_last      <= m_last_nxt;
        n_last      <= n_last_nxt;
      end
    end
  end

  assign cmd_valid = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler with P=Q=KT=8: table-driven jobs plus corner sequences.
module tb_sa_tile_scheduler;
  import sa_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, abort, cmd_ready, cmp_done, wr_done;
  dim_t        cfg_m, cfg_n, cfg_k;
  logic        cmd_valid, cmd_finish, busy, done, err;
  dim_t        cmd_row_len, cmd_col_len, cmd_k_len, cmd_m_off, cmd_n_off, cmd_k_off;
  logic [15:0] cmd_cnt;

  typedef struct {
    int row; int col; int kl; int fin; int mo; int no; int ko;
  } cmd_vec_t;

  typedef struct {
    int m; int n; int k; int ncmd; int stall; int inject_wr;
  } job_vec_t;

  cmd_vec_t cmds[15];
  job_vec_t jobs[4];
  int total = 0;
  int bad   = 0;

  sa_tile_scheduler #(.P(8), .Q(8), .KT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row_len(cmd_row_len), .cmd_col_len(cmd_col_len), .cmd_k_len(cmd_k_len),
    .cmd_finish(cmd_finish), .cmd_m_off(cmd_m_off), .cmd_n_off(cmd_n_off), .cmd_k_off(cmd_k_off),
    .cmp_done(cmp_done), .wr_done(wr_done), .busy(busy), .done(done), .err(err),
    .cmd_cnt(cmd_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int m, input int n, input int k);
    cfg_m = 8'(m);
    cfg_n = 8'(n);
    cfg_k = 8'(k);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!cmd_valid && n < 20) begin
      step();
      n++;
    end
    if (!cmd_valid) check_output({name, " valid timeout"}, 32'(cmd_valid), 1);
  endtask

  task automatic check_fields(input string tag, input cmd_vec_t v);
    check_output({tag, " row_len"}, 32'(cmd_row_len), v.row);
    check_output({tag, " col_len"}, 32'(cmd_col_len), v.col);
    check_output({tag, " k_len"},   32'(cmd_k_len),   v.kl);
    check_output({tag, " finish"},  32'(cmd_finish),  v.fin);
    check_output({tag, " m_off"},   32'(cmd_m_off),   v.mo);
    check_output({tag, " n_off"},   32'(cmd_n_off),   v.no);
    check_output({tag, " k_off"},   32'(cmd_k_off),   v.ko);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " cmd_valid"}, 32'(cmd_valid), 0);
    check_output({tag, " busy"},      32'(busy),      0);
    check_output({tag, " done"},      32'(done),      0);
    check_output({tag, " err"},       32'(err),       0);
    check_output({tag, " cmd_cnt"},   32'(cmd_cnt),   0);
    check_output({tag, " fields"},
                 32'({cmd_row_len, cmd_col_len, cmd_k_len, cmd_m_off} | {cmd_n_off, cmd_k_off, 7'd0, cmd_finish, 8'd0}), 0);
  endtask

  initial begin
    int ci;
    // m, n, k, commands, stall first command, inject wr_done in WAIT_CMP
    jobs[0] = '{8, 8, 8, 1, 0, 0};
    jobs[1] = '{20, 8, 8, 3, 0, 0};
    jobs[2] = '{8, 8, 17, 3, 0, 1};
    jobs[3] = '{9, 9, 9, 8, 1, 0};
    // row, col, k_len, finish, m_off, n_off, k_off
    cmds[0]  = '{8, 8, 8, 1, 0, 0, 0};
    cmds[1]  = '{8, 8, 8, 1, 0, 0, 0};
    cmds[2]  = '{8, 8, 8, 1, 8, 0, 0};
    cmds[3]  = '{4, 8, 8, 1, 16, 0, 0};
    cmds[4]  = '{8, 8, 8, 0, 0, 0, 0};
    cmds[5]  = '{8, 8, 8, 0, 0, 0, 8};
    cmds[6]  = '{8, 8, 1, 1, 0, 0, 16};
    cmds[7]  = '{8, 8, 8, 0, 0, 0, 0};
    cmds[8]  = '{8, 8, 1, 1, 0, 0, 8};
    cmds[9]  = '{8, 1, 8, 0, 0, 8, 0};
    cmds[10] = '{8, 1, 1, 1, 0, 8, 8};
    cmds[11] = '{1, 8, 8, 0, 8, 0, 0};
    cmds[12] = '{1, 8, 1, 1, 8, 0, 8};
    cmds[13] = '{1, 1, 8, 0, 8, 8, 0};
    cmds[14] = '{1, 1, 1, 1, 8, 8, 8};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0;
    cmp_done = 1'b0; wr_done = 1'b0; cfg_m = '0; cfg_n = '0; cfg_k = '0;
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    ci = 0;
    for (int j = 0; j < 4; j++) begin
      apply_stimulus(jobs[j].m, jobs[j].n, jobs[j].k);
      check_output($sformatf("job%0d busy after start", j), 32'(busy), 1);
      check_output($sformatf("job%0d valid after start", j), 32'(cmd_valid), 1);
      for (int c = 0; c < jobs[j].ncmd; c++) begin
        cmd_vec_t v;
        string    tag;
        v   = cmds[ci + c];
        tag = $sformatf("job%0d cmd%0d", j, c);
        wait_valid(tag);
        check_fields(tag, v);
        if (c == 0 && jobs[j].stall != 0) begin
          for (int s = 0; s < 5; s++) begin
            step();
            check_output({tag, " stalled valid"}, 32'(cmd_valid), 1);
            check_fields({tag, " stalled"}, v);
          end
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check_output({tag, " valid after handshake"}, 32'(cmd_valid), 0);
        if (c == 0 && jobs[j].inject_wr != 0) begin
          wr_done = 1'b1;
          step();
          wr_done = 1'b0;
          check_output({tag, " valid after stray wr_done"}, 32'(cmd_valid), 0);
          check_output({tag, " busy after stray wr_done"}, 32'(busy), 1);
        end
        step();
        cmp_done = 1'b1;
        step();
        cmp_done = 1'b0;
        if (v.fin == 0) begin
          check_output({tag, " valid after cmp_done"}, 32'(cmd_valid), 1);
        end else begin
          check_output({tag, " valid in WAIT_WR"}, 32'(cmd_valid), 0);
          step();
          wr_done = 1'b1;
          step();
          wr_done = 1'b0;
          if (c == jobs[j].ncmd - 1) begin
            check_output({tag, " done"}, 32'(done), 1);
            check_output({tag, " busy at end"}, 32'(busy), 0);
            check_output({tag, " cmd_cnt"}, 32'(cmd_cnt), 32'(jobs[j].ncmd));
          end else begin
            check_output({tag, " early done"}, 32'(done), 0);
            check_output({tag, " busy mid job"}, 32'(busy), 1);
          end
        end
      end
      ci += jobs[j].ncmd;
      step();
      check_output($sformatf("job%0d done is a pulse", j), 32'(done), 0);
    end

    // K=255: 32 k-steps, last one 7 long at offset 248 without wrapping
    apply_stimulus(1, 1, 255);
    for (int i = 0; i < 32; i++) begin
      string tag;
      tag = $sformatf("k255 cmd%0d", i);
      wait_valid(tag);
      check_output({tag, " k_len"},   32'(cmd_k_len),  (i < 31) ? 8 : 7);
      check_output({tag, " k_off"},   32'(cmd_k_off),  32'(i * 8));
      check_output({tag, " finish"},  32'(cmd_finish), (i == 31) ? 1 : 0);
      check_output({tag, " row_len"}, 32'(cmd_row_len), 1);
      check_output({tag, " col_len"}, 32'(cmd_col_len), 1);
      if (i == 0) begin
        cfg_m = 8'd0;
        start = 1'b1;
      end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      start = 1'b0;
      if (i == 0) check_output("start while busy err", 32'(err), 0);
      cmp_done = 1'b1;
      step();
      cmp_done = 1'b0;
    end
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check_output("k255 done", 32'(done), 1);
    check_output("k255 cmd_cnt", 32'(cmd_cnt), 32);

    // Zero dimension is rejected
    step();
    apply_stimulus(0, 8, 8);
    check_output("zero err", 32'(err), 1);
    check_output("zero done", 32'(done), 1);
    check_output("zero busy", 32'(busy), 0);
    check_output("zero valid", 32'(cmd_valid), 0);
    step();
    check_output("zero err pulse", 32'(err), 0);
    check_output("zero valid later", 32'(cmd_valid), 0);

    // Abort in WAIT_CMP
    apply_stimulus(8, 8, 8);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("abort busy", 32'(busy), 0);
    check_output("abort valid", 32'(cmd_valid), 0);
    check_output("abort done", 32'(done), 0);
    cmp_done = 1'b1;
    step();
    cmp_done = 1'b0;
    check_output("cmp_done in idle busy", 32'(busy), 0);
    check_output("cmp_done in idle done", 32'(done), 0);

    // Reset while issuing the second k-step
    apply_stimulus(8, 8, 17);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    cmp_done = 1'b1;
    step();
    cmp_done = 1'b0;
    check_output("pre-reset cmd_cnt", 32'(cmd_cnt), 1);
    check_output("pre-reset k_off", 32'(cmd_k_off), 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("mid-job reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
